mmio_router: RTL and testbench
==============================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 Parameter NSLV, default 4: number of address regions; region index width = $clog2(NSLV).
REQ-002 Parameter DW, default 32: data width of CPU and slave buses.
REQ-003 Parameter SEL_LO, default 16: LSB of region-select field addr[SEL_LO+$clog2(NSLV)-1:SEL_LO].
REQ-004 Parameter SLV_EN, default 4'b1110: one bit per region, 1 = mapped; region 0 unmapped by default.
REQ-005 Parameter TMO_CYC, default 15: wait-cycle limit before timeout, range 1..255.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 cpu_req  input  1  access request, held until cpu_ack.
REQ-009 cpu_wr  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-010 cpu_addr  input  32  byte address; sampled with cpu_req.
REQ-011 cpu_wdata  input  DW  write data; sampled with cpu_req.
REQ-012 cpu_rdata  output  DW  registered read data, valid while cpu_ack=1.
REQ-013 cpu_ack  output  1  one-cycle completion pulse.
REQ-014 cpu_err  output  1  one-cycle error pulse, coincident with cpu_ack.
REQ-015 slv_sel  output  NSLV  one-hot slave select.
REQ-016 slv_wr  output  1  write strobe, qualified by slv_sel.
REQ-017 slv_addr, slv_wdata  output  32, DW  captured address and data.
REQ-018 slv_ready  input  NSLV  per-slave completion.
REQ-019 slv_rdata  input  NSLV*DW  packed per-slave read data; slave i at [i*DW +: DW].

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-021 IDLE, cpu_req=1: capture cpu_wr/addr/wdata; decode region; go to ACCESS if the region is mapped, otherwise go to RESP with err and rdata=0.
REQ-022 ACCESS SHALL drive slv_sel one-hot for the captured region, with slv_wr=captured cpu_wr, from the cycle after capture.
REQ-023 ACCESS, slv_ready[region]=1: register slv_rdata of that region (writes register 0), drop slv_sel/slv_wr, go to RESP.
REQ-024 Ready bits of unselected slaves SHALL be ignored.
REQ-025 RESP SHALL assert cpu_ack for exactly one cycle, then return to IDLE; new requests are sampled only in IDLE.
REQ-026 Minimum latency: a slave with ready tied high gives cpu_ack 3 cycles after capture (capture, ACCESS, RESP).
REQ-027 cpu_req deasserted mid-access SHALL NOT abort it; cpu_ack still pulses.
REQ-028 cpu_req held high through RESP SHALL be treated as a new request in the following IDLE cycle.
REQ-029 cpu_rdata SHALL hold its value until the next RESP.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, cpu_ack=0, cpu_err=0, cpu_rdata=0, slv_sel=0, slv_wr=0, slv_addr=0, slv_wdata=0, wait counter=0.
REQ-031 Reset during ACCESS SHALL abandon the access with no ack; the first request after reset release is handled normally.

Configuration
REQ-032 Macro MMIO_TIMEOUT_EN defined: an 8-bit wait counter SHALL count ACCESS cycles; when it reaches TMO_CYC without ready, the router drops slv_sel and goes to RESP with cpu_err=1 and cpu_rdata=0.
REQ-033 Macro not defined: no counter is built, and ACCESS waits indefinitely for ready.

Structure
REQ-034 Package mmio_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the default SLV_EN and TMO_CYC constants, and the region-index function.
REQ-035 Sub-module mmio_decode SHALL be combinational: addr plus SLV_EN in, one-hot select and mapped flag out.

Verification
REQ-036 Read, region 1, addr 0x0001_0004, ready tied high, rdata1=0xDEAD_BEEF -> cpu_ack 3 cycles after capture, cpu_rdata=0xDEAD_BEEF, cpu_err=0.
REQ-037 Write, region 2, addr 0x0002_0010, wdata 0x5, ready after 4 wait cycles -> slv_sel=4'b0100 and slv_wr=1 for 5 cycles, then a single cpu_ack.
REQ-038 Access, addr 0x0000_0100 (region 0, unmapped) -> no slv_sel; cpu_ack and cpu_err on the cycle after capture; cpu_rdata=0.
REQ-039 MMIO_TIMEOUT_EN, TMO_CYC=15, slave 3 never ready -> cpu_err and cpu_ack after 15 ACCESS cycles; slv_sel cleared.
REQ-040 reset_n pulsed low in ACCESS -> all outputs 0 immediately; no ack; a back-to-back read afterwards completes normally.
REQ-041 cpu_req held high across two reads to regions 1 and 3 -> two ack pulses separated by one IDLE cycle; slv_ready[2] toggling has no effect.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO router: FSM state encoding,
// default region map and timeout, and the address-to-region helper.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] DEF_SLV_EN  = 4'b1110;
    localparam int         DEF_TMO_CYC = 15;

    // Extracts the region-select field addr[sel_lo +: sel_w].
    function automatic int unsigned region_idx(input logic [31:0] addr,
                                               input int unsigned sel_lo,
                                               input int unsigned sel_w);
        logic [31:0] mask;
        mask = (32'd1 << sel_w) - 32'd1;
        return int'((addr >> sel_lo) & mask);
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decoder: turns a byte address into a one-hot slave
// select, masked by the map of populated regions.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int NSLV   = 4,
    parameter int SEL_LO = 16
) (
    input  logic [31:0]     addr,
    input  logic [NSLV-1:0] slv_en,
    output logic [NSLV-1:0] sel,
    output logic            mapped
);

    localparam int unsigned RW = (NSLV > 1) ? $clog2(NSLV) : 1;

    always_comb begin
        int unsigned idx;
        idx = region_idx(addr, SEL_LO, RW);
        sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (idx == i) sel[i] = slv_en[i];
        end
        mapped = |sel;
    end

endmodule

// File: rtl/mmio_router.sv
// Single-master MMIO router: decodes the CPU address to one of NSLV slave
// regions and runs one access at a time. Define MMIO_TIMEOUT_EN to bound waits.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int              NSLV    = 4,
    parameter int              DW      = 32,
    parameter int              SEL_LO  = 16,
    parameter logic [NSLV-1:0] SLV_EN  = NSLV'(DEF_SLV_EN),
    parameter int              TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_ack,
    output logic             cpu_err,
    output logic [NSLV-1:0]  slv_sel,
    output logic             slv_wr,
    output logic [31:0]      slv_addr,
    output logic [DW-1:0]    slv_wdata,
    input  logic [NSLV-1:0]  slv_ready,
    input  logic [NSLV*DW-1:0] slv_rdata,
    output logic [1:0]       dbg_state
);

    if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_range
        $error("mmio_router: TMO_CYC must be within 1..255");
    end

    // Handshake: cpu_req is held until the one-cycle cpu_ack; a slave finishes
    // an access by raising its own slv_ready bit while its slv_sel bit is high.
    state_t            state, state_d;
    logic [NSLV-1:0]   sel_d;
    logic              wr_d, ack_d, err_d;
    logic [31:0]       addr_d;
    logic [DW-1:0]     wdata_d, rdata_d, sel_rdata;
    logic [NSLV-1:0]   dec_sel;
    logic              dec_mapped;
    logic              ready_hit;

`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
    logic [7:0] wait_cnt, wait_cnt_d;
`endif

    mmio_decode #(
        .NSLV   (NSLV),
        .SEL_LO (SEL_LO)
    ) u_decode (
        .addr   (cpu_addr),
        .slv_en (SLV_EN),
        .sel    (dec_sel),
        .mapped (dec_mapped)
    );

    // slv_sel is one-hot during ACCESS, so masking with it ignores every other slave.
    assign ready_hit = |(slv_ready & slv_sel);
    assign dbg_state = state;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (slv_sel[i]) sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = slv_sel;
        wr_d    = slv_wr;
        addr_d  = slv_addr;
        wdata_d = slv_wdata;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = cpu_rdata;
`ifdef MMIO_TIMEOUT_EN
        wait_cnt_d = wait_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (dec_mapped) begin
                        sel_d   = dec_sel;
                        wr_d    = cpu_wr;
                        state_d = ACCESS;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (ready_hit) begin
                    rdata_d = slv_wr ? '0 : sel_rdata;
                    sel_d   = '0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RESP;
`ifdef MMIO_TIMEOUT_EN
                    wait_cnt_d = '0;
                end else if (wait_cnt == TMO_LIM - 8'd1) begin
                    rdata_d    = '0;
                    sel_d      = '0;
                    wr_d       = 1'b0;
                    ack_d      = 1'b1;
                    err_d      = 1'b1;
                    state_d    = RESP;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            slv_sel   <= '0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
`ifdef MMIO_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            state     <= state_d;
            slv_sel   <= sel_d;
            slv_wr    <= wr_d;
            slv_addr  <= addr_d;
            slv_wdata <= wdata_d;
            cpu_ack   <= ack_d;
            cpu_err   <= err_d;
            cpu_rdata <= rdata_d;
`ifdef MMIO_TIMEOUT_EN
            wait_cnt  <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: directed accesses against a
// transaction-level model of the address map, slave latencies and responses.
module tb_mmio_router;

    localparam int         DW   = 32;
    localparam int         NSLV = 4;
    localparam logic [3:0] MAP  = 4'b1110;
    localparam int         TMO  = 15;
`ifdef MMIO_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             cpu_req, cpu_wr;
    logic [31:0]      cpu_addr;
    logic [DW-1:0]    cpu_wdata, cpu_rdata;
    logic             cpu_ack, cpu_err;
    logic [NSLV-1:0]  slv_sel;
    logic             slv_wr;
    logic [31:0]      slv_addr;
    logic [DW-1:0]    slv_wdata;
    logic [NSLV-1:0]  slv_ready = '0;
    logic [NSLV*DW-1:0] slv_rdata;
    logic [1:0]       dbg_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Slave behaviour: ready after slv_wait[i] selected cycles, or tied high, or toggling.
    int          slv_wait[NSLV];
    bit          slv_tie[NSLV];
    bit          slv_tog[NSLV];
    int          sel_cnt[NSLV];
    int          sel_len[NSLV];
    logic [DW-1:0] slv_data[NSLV];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          cap;
        int          ack;
        logic        err;
    } txn_t;

    txn_t          txn_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rdata;
    int            cur_cap;

    assign slv_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    mmio_router dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_wr    (slv_wr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_ready (slv_ready),
        .slv_rdata (slv_rdata),
        .dbg_state (dbg_state)
    );

    // Clock and cycle index (cyc = number of rising edges so far).
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave responder.
    always @(negedge clk) begin
        for (int i = 0; i < NSLV; i++) begin
            if (slv_sel[i]) begin
                sel_cnt[i]++;
                sel_len[i] = sel_cnt[i];
            end else begin
                sel_cnt[i] = 0;
            end
            if (slv_tie[i])      slv_ready[i] = 1'b1;
            else if (slv_tog[i]) slv_ready[i] = cyc[0];
            else                 slv_ready[i] = slv_sel[i] && (sel_cnt[i] > slv_wait[i]);
        end
    end

    // Scoreboard compare, once per cycle on the falling edge.
    always @(negedge clk) begin
        txn_t       t;
        logic [3:0] exp_sel;
        logic       exp_wr, exp_ack, exp_err;
        if (!reset_n) begin
            chk("rst_ctl", {cpu_ack, cpu_err, slv_wr, slv_sel}, 64'd0);
            chk("rst_rdata", cpu_rdata, 64'd0);
            chk("rst_slv_bus", {slv_addr, slv_wdata}, 64'd0);
        end else begin
            exp_sel = '0;
            exp_wr  = 1'b0;
            exp_ack = 1'b0;
            exp_err = 1'b0;
            if (txn_q.size() > 0) begin
                t = txn_q[0];
                if (cyc >= t.cap && cyc < t.ack) begin
                    exp_sel = t.sel;
                    exp_wr  = (t.sel != 4'd0) && t.wr;
                end
                if (cyc == t.ack) begin
                    exp_ack = 1'b1;
                    exp_err = t.err;
                end
                if (cyc >= t.cap) chk("slv_addr_data", {slv_addr, slv_wdata}, {t.addr, t.wdata});
            end
            chk("slv_sel", slv_sel, exp_sel);
            chk("slv_wr", slv_wr, exp_wr);
            chk("cpu_ack", cpu_ack, exp_ack);
            chk("cpu_err", cpu_err, exp_err);
            if (exp_ack) begin
                last_rdata = exp_q.pop_front();
                void'(txn_q.pop_front());
            end
            chk("cpu_rdata", cpu_rdata, last_rdata);
        end
    end

    // Driver: called just after a rising edge. in_resp=1 means the router is
    // in its ack cycle, so the request is captured one edge later.
    task automatic start_txn(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input bit in_resp);
        txn_t          t;
        int            r, w;
        logic [DW-1:0] rd;
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        r = int'((addr >> 16) % 4);
        w = slv_wait[r];
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wd;
        t.cap   = cyc + (in_resp ? 2 : 1);
        if (!MAP[r]) begin
            t.sel = 4'd0; t.ack = t.cap;           t.err = 1'b1; rd = '0;
        end else if (TMO_ON && w >= TMO) begin
            t.sel = 4'(1 << r); t.ack = t.cap + TMO; t.err = 1'b1; rd = '0;
        end else begin
            t.sel = 4'(1 << r); t.ack = t.cap + w + 1; t.err = 1'b0;
            rd = wr ? '0 : slv_data[r];
        end
        txn_q.push_back(t);
        exp_q.push_back(rd);
        cur_cap = t.cap;
    endtask

    task automatic wait_ack(input bit hold, input bit drop_early, output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (drop_early && cyc >= cur_cap) cpu_req = 1'b0;
            if (cpu_ack) begin
                ack_cyc = cyc;
                if (!hold) cpu_req = 1'b0;
                break;
            end
        end
        if (ack_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: cpu_ack not seen within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2;
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        last_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            slv_wait[i] = 0; slv_tie[i] = 1'b0; slv_tog[i] = 1'b0;
            sel_cnt[i] = 0; sel_len[i] = 0;
        end
        slv_data[0] = 32'h0BAD_0000;
        slv_data[1] = 32'hDEAD_BEEF;
        slv_data[2] = 32'h2222_0000;
        slv_data[3] = 32'h3333_CAFE;
        slv_tie[1]  = 1'b1;

        idle(3);
        chk("reset_ack", cpu_ack, 64'd0);
        chk("reset_sel", slv_sel, 64'd0);
        reset_n = 1'b1;
        idle(1);

        // Read region 1, ready tied high: ack in the third cycle counting capture.
        start_txn(1'b0, 32'h0001_0004, 32'h0, 1'b0);
        wait_ack(1'b0, 1'b0, a1);
        chk("rd1_latency", 64'(a1 - cur_cap), 64'd1);
        chk("rd1_rdata", cpu_rdata, 64'hDEAD_BEEF);
        chk("rd1_err", cpu_err, 64'd0);
        idle(2);

        // Unmapped region 0: error response on the cycle after capture.
        start_txn(1'b0, 32'h0000_0100, 32'hFFFF, 1'b0);
        wait_ack(1'b0, 1'b0, a1);
        chk("unmapped_latency", 64'(a1 - cur_cap), 64'd0);
        chk("unmapped_err", cpu_err, 64'd1);
        chk("unmapped_rdata", cpu_rdata, 64'd0);
        idle(2);

        // Write region 2 after 4 wait cycles: select held for 5 cycles.
        slv_wait[2] = 4;
        start_txn(1'b1, 32'h0002_0010, 32'h5, 1'b0);
        wait_ack(1'b0, 1'b0, a1);
        chk("wr2_sel_len", 64'(sel_len[2]), 64'd5);
        chk("wr2_latency", 64'(a1 - cur_cap), 64'd5);
        chk("wr2_rdata", cpu_rdata, 64'd0);
        idle(3);

        // Request dropped mid-access still completes.
        slv_wait[3] = 2;
        start_txn(1'b0, 32'h0003_0008, 32'h0, 1'b0);
        wait_ack(1'b0, 1'b1, a1);
        chk("drop_rdata", cpu_rdata, 64'h3333_CAFE);
        chk("drop_latency", 64'(a1 - cur_cap), 64'd3);
        idle(2);

        // Slave 3 very late: timeout build errors out, default build waits.
        slv_wait[3] = 40;
        start_txn(1'b0, 32'h0003_0000, 32'h0, 1'b0);
        wait_ack(1'b0, 1'b0, a1);
`ifdef MMIO_TIMEOUT_EN
        chk("tmo_latency", 64'(a1 - cur_cap), 64'd15);
        chk("tmo_err", cpu_err, 64'd1);
        chk("tmo_rdata", cpu_rdata, 64'd0);
`else
        chk("late_latency", 64'(a1 - cur_cap), 64'd41);
        chk("late_err", cpu_err, 64'd0);
        chk("late_rdata", cpu_rdata, 64'h3333_CAFE);
`endif
        idle(2);

        // Reset pulsed during ACCESS: outputs clear at once, no ack.
        start_txn(1'b0, 32'h0003_0004, 32'h0, 1'b0);
        idle(3);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_ctl", {cpu_ack, cpu_err, slv_wr, slv_sel}, 64'd0);
        chk("rst_mid_rdata", cpu_rdata, 64'd0);
        chk("rst_mid_bus", {slv_addr, slv_wdata}, 64'd0);
        txn_q.delete();
        exp_q.delete();
        last_rdata = '0;
        idle(2);
        reset_n = 1'b1;
        start_txn(1'b0, 32'h0001_0004, 32'h0, 1'b0);
        wait_ack(1'b0, 1'b0, a1);
        chk("post_rst_rdata", cpu_rdata, 64'hDEAD_BEEF);
        chk("post_rst_latency", 64'(a1 - cur_cap), 64'd1);
        idle(2);

        // Request held high across reads to regions 1 and 3; slave 2 ready toggles.
        slv_tog[2] = 1'b1;
        slv_wait[3] = 0;
        start_txn(1'b0, 32'h0001_0000, 32'h0, 1'b0);
        wait_ack(1'b1, 1'b0, a1);
        chk("b2b_rd1", cpu_rdata, 64'hDEAD_BEEF);
        start_txn(1'b0, 32'h0003_0000, 32'h0, 1'b1);
        wait_ack(1'b0, 1'b0, a2);
        chk("b2b_rd3", cpu_rdata, 64'h3333_CAFE);
        // Ack, IDLE, ACCESS, ack: pulses three edges apart.
        chk("b2b_ack_gap", 64'(a2 - a1), 64'd3);
        slv_tog[2] = 1'b0;
        idle(4);
        chk("scoreboard_drained", 64'(txn_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
